mul_div_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, beside the main ALU. The decoder starts it for R-type instructions with Funct7 = 0000001 (ALUOp = 10); it reuses the same Funct3 field the ALU controller decodes. It runs one radix-2 step per clock over WIDTH cycles with fixed latency. The hazard unit stalls the pipeline while `busy` is high.

---
 rtl/mul_div_unit.sv | 130 +++++++++++++
 tb/tb_mul_div_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per clock, fixed WIDTH+1 edge latency.
// Multiply and divide share one pair of working registers (hi/lo) and one operand register.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [2:0]       op;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi, lo, opnd;
  logic             neg_res, neg_rem, div_by_zero, overflow;

  logic             is_div, a_signed, b_signed, sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   add_sum, shifted, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quot, rem, fix_result;

  // Operand decode: the core works on unsigned magnitudes, signs are reapplied in FIX.
  always_comb begin
    is_div   = Funct3[2];
    a_signed = is_div ? ~Funct3[0] : (Funct3 == 3'b001 || Funct3 == 3'b010);
    b_signed = is_div ? ~Funct3[0] : (Funct3 == 3'b001);
    sign_a   = a_signed & SrcA[WIDTH-1];
    sign_b   = b_signed & SrcB[WIDTH-1];
    mag_a    = sign_a ? -SrcA : SrcA;
    mag_b    = sign_b ? -SrcB : SrcB;
  end

  always_comb begin
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
  end

  // With a zero divisor the remainder register ends up holding the dividend magnitude,
  // so the signed remainder path already yields SrcA for REM/REMU by zero.
  always_comb begin
    prod  = neg_res ? -{hi, lo} : {hi, lo};
    quot  = neg_res ? -lo : lo;
    rem   = neg_rem ? -hi : hi;
    fix_result = '0;
    if (!op[2])
      fix_result = (op[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    else if (div_by_zero)
      fix_result = op[1] ? rem : '1;
    else if (overflow)
      fix_result = op[1] ? '0 : MIN_NEG;
    else
      fix_result = op[1] ? rem : quot;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      Result      <= '0;
      count       <= '0;
      op          <= 3'b000;
      hi          <= '0;
      lo          <= '0;
      opnd        <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            op          <= Funct3;
            count       <= '0;
            neg_res     <= sign_a ^ sign_b;
            neg_rem     <= sign_a;
            div_by_zero <= (SrcB == '0);
            overflow    <= is_div && !Funct3[0] && (SrcA == MIN_NEG) && (SrcB == '1);
            hi          <= '0;
            lo          <= is_div ? mag_a : mag_b;
            opnd        <= is_div ? mag_b : mag_a;
          end
        end
        RUN: begin
          // Divide: restoring shift-subtract; multiply: shift-add with the multiplier in lo.
          if (op[2]) begin
            if (!diff[WIDTH]) begin
              hi <= diff[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
              hi <= shifted[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi <= add_sum[WIDTH:1];
            lo <= {add_sum[0], lo[WIDTH-1:1]};
          end
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1))
            state <= FIX;
        end
        FIX: begin
          Result <= fix_result;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed RV32M cases, handshake/reset scenarios
// and randomized operations against a plain-arithmetic reference model.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int passes = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .Funct3(funct3),
    .SrcA(src_a), .SrcB(src_b), .busy(busy), .done(done), .Result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written from the RV32M rules using 64-bit and signed integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb;
    if (!f3[2]) begin
      ea = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
      eb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = ea * eb;
      return (f3 == 3'd0) ? p[31:0] : p[63:32];
    end
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
      sa = a;
      sb = b;
      return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return f3[1] ? (a % b) : (a / b);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Called at a negedge; drives the request so that the next rising edge (edge n) samples it.
  task automatic launch(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    funct3 = f3;
    src_a  = a;
    src_b  = b;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
    check({tag, " done_after_start"}, {31'd0, done}, 32'd0);
  endtask

  // Waits (bounded) for done, checking latency, busy coverage and the result.
  // disturb_at >= 0 re-asserts start with new operands so edge n+disturb_at+1 samples it.
  task automatic finish_op(input string tag, input logic [31:0] exp, input int disturb_at);
    int lat;
    bit busy_ok;
    lat = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (lat == disturb_at) begin
        start  = 1'b1;
        funct3 = ~funct3;
        src_a  = $urandom;
        src_b  = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'd33);
    check({tag, " busy_while_running"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, " result"}, result, exp);
  endtask

  task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    launch(tag, f3, a, b);
    finish_op(tag, model(f3, a, b), -1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rf;
    bit          saw_done;

    reset  = 1'b0;
    start  = 1'b1;
    funct3 = 3'd0;
    src_a  = 32'd1;
    src_b  = 32'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    applyStimulus("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD);
    check("mul_7_m3 model", model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    applyStimulus("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
    applyStimulus("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus("mulhsu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
    applyStimulus("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
    applyStimulus("divu_big", 3'd5, 32'hFFFF_FFFE, 32'd2);
    applyStimulus("remu_10_3", 3'd7, 32'd10, 32'd3);
    applyStimulus("div_by_zero", 3'd4, 32'd5, 32'd0);
    applyStimulus("remu_by_zero", 3'd7, 32'd5, 32'd0);
    applyStimulus("rem_neg_by_zero", 3'd6, 32'hFFFF_FFF9, 32'd0);
    applyStimulus("div_overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus("rem_overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // Start during RUN with changed operands must be ignored.
    launch("ignored_start", 3'd0, 32'd1234, 32'd5678);
    finish_op("ignored_start", 32'd7006652, 4);

    // Back-to-back: the request is already up while done is high, so edge n+34 accepts it.
    launch("back_to_back", 3'd5, 32'd1000, 32'd7);
    finish_op("back_to_back", 32'd142, -1);
    launch("back_to_back_2", 3'd1, 32'hFFFF_FFFE, 32'h4000_0000);
    finish_op("back_to_back_2", 32'hFFFF_FFFF, -1);
    @(posedge clk);
    @(negedge clk);
    check("done_single_pulse", {31'd0, done}, 32'd0);

    // Reset at edge n+10 abandons the operation.
    launch("reset_mid", 3'd4, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_mid busy", {31'd0, busy}, 32'd0);
    check("reset_mid done", {31'd0, done}, 32'd0);
    check("reset_mid result", result, 32'd0);
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("reset_mid no_done", {31'd0, saw_done}, 32'd0);
    applyStimulus("mulhu_3_5", 3'd3, 32'd3, 32'd5);

    for (int i = 0; i < 30; i++) begin
      rf = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      applyStimulus($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
